wb_copy: RTL
============

Name: wb_copy

Overview:
- Wishbone pipelined bus master (initiator) that copies a block of words from a source address range to a destination address range.
- Moves data in chunks of up to DEPTH words: pipelined reads into a local buffer, then pipelined writes from that buffer.
- Sits on the same Wishbone fabric as the RAM slaves; started from the J1 I/O space or a testbench via a start/len command port.

Parameters:
- AW, 16, Wishbone address width (word addresses).
- DW, 16, Wishbone data width.
- DEPTH, 8, chunk buffer depth in words; power of 2, at least 2.
- LENW, 16, width of the length field.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- start  in  1  command strobe; sampled only in IDLE.
- src_adr  in  AW  first source word address.
- dst_adr  in  AW  first destination word address.
- len  in  LENW  number of words to copy.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle completion pulse.
- wb_cyc  out  1  Wishbone cycle.
- wb_stb  out  1  Wishbone strobe.
- wb_we  out  1  write enable.
- wb_adr  out  AW  address.
- wb_dat_m  out  DW  write data.
- wb_dat_s  in  DW  read data.
- wb_ack  in  1  acknowledge.
- wb_stall  in  1  slave stall.

Behaviour:
- Interface: one clock, clk; rst is asynchronous, active-high. All flops are clocked on posedge clk and cleared on posedge rst.
- Reset values:
  - state=IDLE.
  - busy, done, wb_cyc, wb_stb and wb_we are 0.
  - wb_adr and wb_dat_m are 0.
  - All counters and pointers are 0.
- A reset mid-transfer aborts immediately: cyc/stb drop asynchronously and no done pulse is produced.
- States: IDLE, RD, WR. busy = (state != IDLE). wb_cyc = busy.
- IDLE:
  - start=1 and len!=0: latch src_ptr=src_adr, dst_ptr=dst_adr, remaining=len; chunk=min(len,DEPTH); go to RD.
  - start=1 and len==0: done=1 in the next cycle; stay in IDLE.
- start while busy is ignored.
- Strobe acceptance: a strobe is accepted in a cycle where wb_stb=1 and wb_stall=0. Only then do the address, data and issue counter advance. While stalled, adr/dat/we hold steady.
- RD:
  - wb_we=0, wb_adr=src_ptr.
  - wb_stb=1 while issued<chunk.
  - On each acceptance: src_ptr++ and issued++.
  - On each wb_ack: buf[rcvd]<=wb_dat_s, rcvd++.
  - When the ack for word chunk-1 arrives: clear issued/rcvd and go to WR next cycle. wb_cyc stays high.
- WR:
  - wb_we=1, wb_adr=dst_ptr, wb_dat_m=buf[issued].
  - wb_stb=1 while issued<chunk.
  - On acceptance: dst_ptr++ and issued++. Each wb_ack increments rcvd.
  - On the final ack: remaining-=chunk.
    - If remaining==0: go to IDLE; done=1 for exactly the next cycle; wb_cyc=0.
    - Otherwise: go to RD with chunk=min(remaining,DEPTH); wb_cyc stays high.
- An ack in the same cycle as an acceptance is legal; the issue and ack counters are independent.
- An ack with zero outstanding requests is ignored; it neither writes the buffer nor increments rcvd.
- Address pointers wrap modulo 2^AW. len up to 2^LENW-1 is legal.
- Timing with a zero-wait slave (ack one cycle after acceptance, stall=0), start sampled in cycle 0, N<=DEPTH:
  - read strobes in cycles 1..N, last read ack in N+1;
  - write strobes in N+2..2N+1, last write ack in 2N+2;
  - done=1 in 2N+3.
- Sustained throughput is one word per cycle per phase.
- wb_stb is never high while wb_cyc is low. wb_we is constant within a phase.

Decomposition:
- Package wb_copy_pkg holds:
  - typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  - localparam CNTW=$clog2(DEPTH)+1 for the issued/rcvd counters.
- One sub-module, wb_copy_buf: DEPTH x DW register file with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata). No reset on its storage.

Test Plan:
- Single-chunk copy, zero-wait slave: preload RAM[0x010..0x014]=0xA000..0xA004; start src=0x010, dst=0x100, len=5.
  -> Reads at 0x010..0x014 in cycles 1-5; writes of 0xA000..0xA004 at 0x100..0x104 in cycles 7-11; done in cycle 13. RAM[0x100..0x104] matches the source.
- Multi-chunk: len=20, DEPTH=8.
  -> Chunks of 8, 8 and 4; wb_cyc continuously high; exactly 20 reads then 20 writes interleaved per chunk; one done pulse; dst contents match src.
- Random stall injection (stall=1 with 50% probability), len=11.
  -> wb_adr/wb_dat_m/wb_we stable during stall; no duplicate or skipped addresses; data correct.
- len=0 start -> no wb_cyc at all; done=1 exactly one cycle later; busy stays 0. A start pulse while busy -> ignored; transfer unaffected.
- Address wrap: src=0xFFFE, dst=0x0010, len=4.
  -> Reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Async reset mid-RD after 3 accepted strobes.
  -> wb_cyc/wb_stb/busy are 0 before the next clk edge; no done pulse; a subsequent start copies correctly.

Source files
------------

// File: rtl/wb_copy_pkg.sv
// Shared types and sizing helpers for the wb_copy block-copy bus master.
package wb_copy_pkg;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    localparam int DEPTH_DEF = 8;

    // Issue/ack counters must reach DEPTH itself, hence one extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CNTW = cnt_w(DEPTH_DEF);

endpackage

// File: rtl/wb_copy_if.sv
// Wishbone pipelined bus bundle between the copy engine and the fabric.
interface wb_copy_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_we;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_dat_m;
    logic [DW-1:0] wb_dat_s;
    logic          wb_ack;
    logic          wb_stall;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_m,
        input  wb_dat_s, wb_ack, wb_stall
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_m,
        output wb_dat_s, wb_ack, wb_stall
    );
endinterface

// File: rtl/wb_copy_buf.sv
// Chunk buffer: DEPTH x DW register file, one synchronous write port and
// one combinational read port; storage is intentionally not reset.
module wb_copy_buf #(
    parameter int DEPTH = 8,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DW-1:0]            rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/wb_copy.sv
// Wishbone pipelined block copier: reads up to DEPTH words into a local
// buffer, writes them back out, and repeats until len words are moved.
module wb_copy
    import wb_copy_pkg::*;
#(
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int DEPTH = 8,
    parameter int LENW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   src_adr,
    input  logic [AW-1:0]   dst_adr,
    input  logic [LENW-1:0] len,
    output logic            busy,
    output logic            done,
    wb_copy_if.master       wb
);
    localparam int CW = cnt_w(DEPTH);
    localparam int IW = $clog2(DEPTH);

    state_t          state_q, state_d;
    logic [AW-1:0]   src_q, src_d, dst_q, dst_d;
    logic [LENW-1:0] rem_q, rem_d;
    logic [CW-1:0]   chunk_q, chunk_d, iss_q, iss_d, rcv_q, rcv_d;
    logic            done_q, done_d;

    logic            accept, ack_ok, last_ack;
    logic [LENW-1:0] rem_left;
    logic [DW-1:0]   buf_rdata;

    function automatic logic [CW-1:0] clip(input logic [LENW-1:0] n);
        if (n >= LENW'(DEPTH)) return CW'(DEPTH);
        return n[CW-1:0];
    endfunction

    // Bus outputs decode straight from state so an async reset drops cyc/stb at once.
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign wb.wb_cyc    = busy;
    assign wb.wb_stb    = busy && (iss_q < chunk_q);
    assign wb.wb_we     = (state_q == WR);
    assign wb.wb_adr    = (state_q == RD) ? src_q : (state_q == WR) ? dst_q : '0;
    assign wb.wb_dat_m  = (state_q == WR) ? buf_rdata : '0;

    assign accept   = wb.wb_stb && !wb.wb_stall;
    // Acks with nothing outstanding are dropped.
    assign ack_ok   = busy && wb.wb_ack && (iss_q > rcv_q);
    assign last_ack = ack_ok && (rcv_q == chunk_q - CW'(1));
    assign rem_left = rem_q - LENW'(chunk_q);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        chunk_d = chunk_q;
        iss_d   = accept ? iss_q + CW'(1) : iss_q;
        rcv_d   = ack_ok ? rcv_q + CW'(1) : rcv_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        src_d   = src_adr;
                        dst_d   = dst_adr;
                        rem_d   = len;
                        chunk_d = clip(len);
                        state_d = RD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RD: begin
                if (accept) src_d = src_q + AW'(1);
                if (last_ack) begin
                    iss_d   = '0;
                    rcv_d   = '0;
                    state_d = WR;
                end
            end
            WR: begin
                if (accept) dst_d = dst_q + AW'(1);
                if (last_ack) begin
                    iss_d = '0;
                    rcv_d = '0;
                    rem_d = rem_left;
                    if (rem_left == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        chunk_d = clip(rem_left);
                        state_d = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            chunk_q <= '0;
            iss_q   <= '0;
            rcv_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            chunk_q <= chunk_d;
            iss_q   <= iss_d;
            rcv_q   <= rcv_d;
            done_q  <= done_d;
        end
    end

    wb_copy_buf #(.DEPTH(DEPTH), .DW(DW)) u_buf (
        .clk     (clk),
        .we_i    ((state_q == RD) && ack_ok),
        .waddr_i (rcv_q[IW-1:0]),
        .wdata_i (wb.wb_dat_s),
        .raddr_i (iss_q[IW-1:0]),
        .rdata_o (buf_rdata)
    );
endmodule
